bcd_scan_counter: RTL and testbench

BCD_SCAN_COUNTER -- requirements
Module: bcd_scan_counter

---
 rtl/bcd_scan_counter_if.sv | 22 ++
 rtl/bcd_scan_counter.sv | 83 ++++++++
 tb/tb_bcd_scan_counter.sv | 270 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/bcd_scan_counter_if.sv
// Control and status bundle for the BCD scan counter.
// The master drives control; the slave (the counter) returns index and pulses.
interface bcd_scan_counter_if;
    logic       en;
    logic       up;
    logic       load;
    logic [3:0] load_val;
    logic [3:0] a;
    logic       step;
    logic       tc;
    logic       load_err;

    modport master (
        output en, up, load, load_val,
        input  a, step, tc, load_err
    );

    modport slave (
        input  en, up, load, load_val,
        output a, step, tc, load_err
    );
endinterface

// File: rtl/bcd_scan_counter.sv
// Decimal 0..9 scan index with a DWELL-cycle prescaler, used to
// sequence a 4-to-10 active-low decoder; loadable and reversible.
module bcd_scan_counter #(
    parameter int unsigned DWELL = 5
) (
    input  logic                clk,
    input  logic                rst,
    bcd_scan_counter_if.slave   bus
);

    localparam int unsigned PW = (DWELL > 1) ? $clog2(DWELL) : 1;
    localparam logic [PW-1:0] PRE_MAX = PW'(DWELL - 1);

    logic [3:0]    a_q, a_d;
    logic [PW-1:0] pre_q, pre_d;
    logic          step_q, step_d;
    logic          tc_q, tc_d;
    logic          err_q, err_d;

    assign bus.a        = a_q;
    assign bus.step     = step_q;
    assign bus.tc       = tc_q;
    assign bus.load_err = err_q;

    // Next state: load beats stepping, stepping beats hold; pulses default low.
    always_comb begin
        a_d    = a_q;
        pre_d  = pre_q;
        step_d = 1'b0;
        tc_d   = 1'b0;
        err_d  = 1'b0;
        if (bus.load) begin
            // Out-of-range values are refused so the index stays decimal.
            if (bus.load_val <= 4'd9) begin
                a_d   = bus.load_val;
                pre_d = '0;
            end else begin
                err_d = 1'b1;
            end
        end else if (bus.en) begin
            if (pre_q == PRE_MAX) begin
                pre_d  = '0;
                step_d = 1'b1;
                // Direction is sampled only on the advancing edge.
                if (bus.up) begin
                    if (a_q >= 4'd9) begin
                        a_d  = 4'd0;
                        tc_d = 1'b1;
                    end else begin
                        a_d = a_q + 4'd1;
                    end
                end else begin
                    if (a_q == 4'd0) begin
                        a_d  = 4'd9;
                        tc_d = 1'b1;
                    end else begin
                        a_d = a_q - 4'd1;
                    end
                end
            end else begin
                pre_d = pre_q + 1'b1;
            end
        end
    end

    // State register with asynchronous clear of index, prescaler and pulses.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_q    <= 4'd0;
            pre_q  <= '0;
            step_q <= 1'b0;
            tc_q   <= 1'b0;
            err_q  <= 1'b0;
        end else begin
            a_q    <= a_d;
            pre_q  <= pre_d;
            step_q <= step_d;
            tc_q   <= tc_d;
            err_q  <= err_d;
        end
    end

endmodule

// File: tb/tb_bcd_scan_counter.sv
// Directed bench for bcd_scan_counter: DWELL=5 and DWELL=1 instances.
// Each task drives one scenario and checks outputs 1 time unit after the edge.
module tb_bcd_scan_counter;

    logic clk;
    logic rst;
    int   tests;
    int   fails;

    bcd_scan_counter_if b5 ();
    bcd_scan_counter_if b1 ();

    bcd_scan_counter #(.DWELL(5)) dut5 (.clk(clk), .rst(rst), .bus(b5));
    bcd_scan_counter #(.DWELL(1)) dut1 (.clk(clk), .rst(rst), .bus(b1));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        #2;
        tests++;
        if (b5.a !== 4'd0 || b5.step !== 1'b0 || b5.tc !== 1'b0 || b5.load_err !== 1'b0) begin
            $display("FAIL reset5: a=%0d step=%b tc=%b err=%b want 0,0,0,0", b5.a, b5.step, b5.tc, b5.load_err);
            fails++;
        end
        tests++;
        if (b1.a !== 4'd0 || b1.step !== 1'b0 || b1.tc !== 1'b0 || b1.load_err !== 1'b0) begin
            $display("FAIL reset1: a=%0d step=%b tc=%b err=%b want 0,0,0,0", b1.a, b1.step, b1.tc, b1.load_err);
            fails++;
        end
        #10;
        rst = 1'b0;
    endtask

    task automatic test_count_up();
        int nstep;
        int ntc;
        logic [3:0] ea;
        logic es;
        logic et;
        nstep = 0;
        ntc = 0;
        b5.en = 1'b1;
        b5.up = 1'b1;
        for (int k = 1; k <= 50; k++) begin
            tick();
            ea = 4'((k / 5) % 10);
            es = (k % 5 == 0);
            et = (k == 50);
            if (b5.step === 1'b1) nstep++;
            if (b5.tc === 1'b1) ntc++;
            tests++;
            if (b5.a !== ea || b5.step !== es || b5.tc !== et) begin
                $display("FAIL count_up k=%0d: a=%0d step=%b tc=%b want %0d,%b,%b", k, b5.a, b5.step, b5.tc, ea, es, et);
                fails++;
            end
        end
        tests++;
        if (nstep != 10 || ntc != 1) begin
            $display("FAIL count_up_pulses: step=%0d tc=%0d want 10,1", nstep, ntc);
            fails++;
        end
        b5.en = 1'b0;
    endtask

    task automatic test_load_down();
        logic [3:0] ea;
        b5.load = 1'b1;
        b5.load_val = 4'd2;
        tick();
        tests++;
        if (b5.a !== 4'd2 || b5.step !== 1'b0 || b5.load_err !== 1'b0) begin
            $display("FAIL load2: a=%0d step=%b err=%b want 2,0,0", b5.a, b5.step, b5.load_err);
            fails++;
        end
        b5.load = 1'b0;
        b5.en = 1'b1;
        b5.up = 1'b0;
        for (int k = 1; k <= 15; k++) begin
            tick();
            if (k < 5) ea = 4'd2;
            else if (k < 10) ea = 4'd1;
            else if (k < 15) ea = 4'd0;
            else ea = 4'd9;
            tests++;
            if (b5.a !== ea || b5.tc !== (k == 15) || b5.step !== (k % 5 == 0)) begin
                $display("FAIL load_down k=%0d: a=%0d tc=%b step=%b want %0d", k, b5.a, b5.tc, b5.step, ea);
                fails++;
            end
        end
        b5.en = 1'b0;
    endtask

    task automatic test_load_reject();
        b5.load = 1'b1;
        b5.load_val = 4'd7;
        tick();
        b5.load = 1'b0;
        b5.en = 1'b1;
        b5.up = 1'b1;
        tick();
        tick();
        b5.load = 1'b1;
        b5.load_val = 4'd12;
        tick();
        tests++;
        if (b5.a !== 4'd7 || b5.load_err !== 1'b1 || b5.step !== 1'b0 || b5.tc !== 1'b0) begin
            $display("FAIL reject: a=%0d err=%b step=%b tc=%b want 7,1,0,0", b5.a, b5.load_err, b5.step, b5.tc);
            fails++;
        end
        b5.load = 1'b0;
        tick();
        tick();
        tests++;
        if (b5.a !== 4'd7 || b5.load_err !== 1'b0 || b5.step !== 1'b0) begin
            $display("FAIL reject_hold: a=%0d err=%b step=%b want 7,0,0", b5.a, b5.load_err, b5.step);
            fails++;
        end
        tick();
        tests++;
        if (b5.a !== 4'd8 || b5.step !== 1'b1) begin
            $display("FAIL reject_pre: a=%0d step=%b want 8,1", b5.a, b5.step);
            fails++;
        end
        b5.en = 1'b0;
    endtask

    task automatic test_enable_gap();
        int nstep;
        nstep = 0;
        b5.load = 1'b1;
        b5.load_val = 4'd0;
        tick();
        b5.load = 1'b0;
        b5.up = 1'b1;
        b5.en = 1'b1;
        for (int k = 0; k < 9; k++) begin
            b5.en = (k < 3 || k >= 7);
            tick();
            if (b5.step === 1'b1) nstep++;
            tests++;
            if (b5.a !== ((k == 8) ? 4'd1 : 4'd0)) begin
                $display("FAIL en_gap k=%0d: a=%0d step=%b", k, b5.a, b5.step);
                fails++;
            end
        end
        tests++;
        if (nstep != 1) begin
            $display("FAIL en_gap_steps: got %0d want 1", nstep);
            fails++;
        end
        b5.en = 1'b0;
    endtask

    task automatic test_dir_change();
        b5.load = 1'b1;
        b5.load_val = 4'd5;
        tick();
        b5.load = 1'b0;
        b5.en = 1'b1;
        b5.up = 1'b1;
        tick();
        tick();
        tick();
        b5.up = 1'b0;
        tick();
        tick();
        tests++;
        if (b5.a !== 4'd4 || b5.step !== 1'b1 || b5.tc !== 1'b0) begin
            $display("FAIL dir_change: a=%0d step=%b tc=%b want 4,1,0", b5.a, b5.step, b5.tc);
            fails++;
        end
        b5.en = 1'b0;
    endtask

    task automatic test_dwell1();
        logic [3:0] ea [0:3];
        ea[0] = 4'd9;
        ea[1] = 4'd0;
        ea[2] = 4'd1;
        ea[3] = 4'd2;
        b1.en = 1'b1;
        b1.up = 1'b1;
        b1.load = 1'b1;
        b1.load_val = 4'd9;
        for (int k = 0; k < 4; k++) begin
            tick();
            b1.load = 1'b0;
            tests++;
            if (b1.a !== ea[k] || b1.step !== (k != 0) || b1.tc !== (k == 1)) begin
                $display("FAIL dwell1 k=%0d: a=%0d step=%b tc=%b want %0d", k, b1.a, b1.step, b1.tc, ea[k]);
                fails++;
            end
        end
        b1.en = 1'b0;
    endtask

    task automatic test_async_reset();
        b5.load = 1'b1;
        b5.load_val = 4'd5;
        tick();
        b5.load = 1'b0;
        b5.en = 1'b1;
        b5.up = 1'b1;
        for (int k = 0; k < 8; k++) tick();
        tests++;
        if (b5.a !== 4'd6) begin
            $display("FAIL arst_setup: a=%0d want 6", b5.a);
            fails++;
        end
        #2;
        rst = 1'b1;
        #1;
        tests++;
        if (b5.a !== 4'd0 || b5.step !== 1'b0 || b5.tc !== 1'b0 || b5.load_err !== 1'b0) begin
            $display("FAIL arst_async: a=%0d step=%b tc=%b err=%b want 0,0,0,0", b5.a, b5.step, b5.tc, b5.load_err);
            fails++;
        end
        b5.load = 1'b1;
        b5.load_val = 4'd3;
        tick();
        tests++;
        if (b5.a !== 4'd0 || b5.step !== 1'b0) begin
            $display("FAIL arst_ignore: a=%0d step=%b want 0,0", b5.a, b5.step);
            fails++;
        end
        #3;
        b5.load = 1'b0;
        rst = 1'b0;
        for (int k = 1; k <= 5; k++) begin
            tick();
            tests++;
            if (b5.a !== ((k == 5) ? 4'd1 : 4'd0) || b5.step !== (k == 5)) begin
                $display("FAIL arst_redwell k=%0d: a=%0d step=%b", k, b5.a, b5.step);
                fails++;
            end
        end
        b5.en = 1'b0;
    endtask

    initial begin
        tests = 0;
        fails = 0;
        rst = 1'b1;
        b5.en = 1'b0;
        b5.up = 1'b1;
        b5.load = 1'b0;
        b5.load_val = 4'd0;
        b1.en = 1'b0;
        b1.up = 1'b1;
        b1.load = 1'b0;
        b1.load_val = 4'd0;
        test_reset();
        test_count_up();
        test_load_down();
        test_load_reject();
        test_enable_gap();
        test_dir_change();
        test_dwell1();
        test_async_reset();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
